// File: rtl/tiny_tpu_pkg.sv
// Shared types for the tiny TPU datapath: element width, skew FSM states, 2x2 tile layout.
package tiny_tpu_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED0 = 2'd1,
    FEED1 = 2'd2,
    FEED2 = 2'd3
  } setup_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] t00;
    logic [DATA_WIDTH-1:0] t01;
    logic [DATA_WIDTH-1:0] t10;
    logic [DATA_WIDTH-1:0] t11;
  } tile_t;

endpackage

// File: rtl/input_setup.sv
// Double-buffered diagonal skew of a 2x2 tile into the systolic row inputs over 3 cycles.
// Optional INPUT_SETUP_TRANSPOSE_EN swaps t01/t10 on capture; DATA_WIDTH must equal the package width.
module input_setup
  import tiny_tpu_pkg::*;
#(
  parameter int DATA_WIDTH = tiny_tpu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  capture,
  input  logic [DATA_WIDTH-1:0] in_00,
  input  logic [DATA_WIDTH-1:0] in_01,
  input  logic [DATA_WIDTH-1:0] in_10,
  input  logic [DATA_WIDTH-1:0] in_11,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] a_row0,
  output logic [DATA_WIDTH-1:0] a_row1,
  output logic                  valid_row0,
  output logic                  valid_row1,
  output logic                  busy,
  output logic                  tile_done,
  output logic                  overrun
);

  setup_state_t state, next_state;
  tile_t        staging, active, next_active, cap_tile;
  logic         staged_valid;
  logic         launch;

  logic [DATA_WIDTH-1:0] nxt_a_row0, nxt_a_row1;
  logic                  nxt_valid_row0, nxt_valid_row1, nxt_busy, nxt_tile_done;

  always_comb begin
    cap_tile.t00 = in_00;
    cap_tile.t11 = in_11;
`ifdef INPUT_SETUP_TRANSPOSE_EN
    cap_tile.t01 = in_10;
    cap_tile.t10 = in_01;
`else
    cap_tile.t01 = in_01;
    cap_tile.t10 = in_10;
`endif
  end

  // A new tile may launch from IDLE or on the last feed cycle, which is what makes streaming gapless.
  assign launch = staged_valid && (state == IDLE || state == FEED2);
  assign ready  = !staged_valid || launch;

  always_comb begin
    next_state  = state;
    next_active = active;
    if (launch) begin
      next_state  = FEED0;
      next_active = staging;
    end else begin
      case (state)
        FEED0:   next_state = FEED1;
        FEED1:   next_state = FEED2;
        FEED2:   next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    nxt_a_row0     = '0;
    nxt_a_row1     = '0;
    nxt_valid_row0 = 1'b0;
    nxt_valid_row1 = 1'b0;
    nxt_tile_done  = 1'b0;
    nxt_busy       = (next_state != IDLE);
    case (next_state)
      FEED0: begin
        nxt_valid_row0 = 1'b1;
        nxt_a_row0     = next_active.t00;
      end
      FEED1: begin
        nxt_valid_row0 = 1'b1;
        nxt_a_row0     = next_active.t01;
        nxt_valid_row1 = 1'b1;
        nxt_a_row1     = next_active.t10;
      end
      FEED2: begin
        nxt_valid_row1 = 1'b1;
        nxt_a_row1     = next_active.t11;
        nxt_tile_done  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      staging      <= '0;
      active       <= '0;
      staged_valid <= 1'b0;
      overrun      <= 1'b0;
      a_row0       <= '0;
      a_row1       <= '0;
      valid_row0   <= 1'b0;
      valid_row1   <= 1'b0;
      busy         <= 1'b0;
      tile_done    <= 1'b0;
    end else begin
      state        <= next_state;
      active       <= next_active;
      staged_valid <= (capture && ready) || (staged_valid && !launch);
      if (capture && ready) staging <= cap_tile;
      if (capture && !ready) overrun <= 1'b1;
      a_row0       <= nxt_a_row0;
      a_row1       <= nxt_a_row1;
      valid_row0   <= nxt_valid_row0;
      valid_row1   <= nxt_valid_row1;
      busy         <= nxt_busy;
      tile_done    <= nxt_tile_done;
    end
  end

endmodule

// File: tb/tb_input_setup.sv
// Directed bench for input_setup: reset, single tile, back-to-back, coincident capture/launch, overrun, mid-feed reset.
module tb_input_setup;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          capture;
  logic [DW-1:0] in_00, in_01, in_10, in_11;
  logic          ready;
  logic [DW-1:0] a_row0, a_row1;
  logic          valid_row0, valid_row1, busy, tile_done, overrun;

  int vec_cnt  = 0;
  int miscmp   = 0;

  input_setup #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .capture    (capture),
    .in_00      (in_00),
    .in_01      (in_01),
    .in_10      (in_10),
    .in_11      (in_11),
    .ready      (ready),
    .a_row0     (a_row0),
    .a_row1     (a_row1),
    .valid_row0 (valid_row0),
    .valid_row1 (valid_row1),
    .busy       (busy),
    .tile_done  (tile_done),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cap(input logic [DW-1:0] e00, input logic [DW-1:0] e01,
                           input logic [DW-1:0] e10, input logic [DW-1:0] e11);
    capture = 1'b1;
    in_00 = e00; in_01 = e01; in_10 = e10; in_11 = e11;
  endtask

  task automatic expect_out(input string tag, input logic v0, input logic [DW-1:0] r0,
                            input logic v1, input logic [DW-1:0] r1,
                            input logic b, input logic d);
    chk({tag, ".valid_row0"}, 32'(valid_row0), 32'(v0));
    chk({tag, ".a_row0"},     32'(a_row0),     32'(r0));
    chk({tag, ".valid_row1"}, 32'(valid_row1), 32'(v1));
    chk({tag, ".a_row1"},     32'(a_row1),     32'(r1));
    chk({tag, ".busy"},       32'(busy),       32'(b));
    chk({tag, ".tile_done"},  32'(tile_done),  32'(d));
  endtask

  // FEED1 expectation: row0 carries t01 and row1 carries t10, swapped when transposing.
  task automatic expect_feed1(input string tag, input logic [DW-1:0] e01, input logic [DW-1:0] e10);
`ifdef INPUT_SETUP_TRANSPOSE_EN
    expect_out(tag, 1'b1, e10, 1'b1, e01, 1'b1, 1'b0);
`else
    expect_out(tag, 1'b1, e01, 1'b1, e10, 1'b1, 1'b0);
`endif
  endtask

  initial begin
    reset = 1'b1; capture = 1'b0;
    in_00 = '0; in_01 = '0; in_10 = '0; in_11 = '0;
    tick(); tick();
    expect_out("rst", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("rst.ready", 32'(ready), 32'd1);
    chk("rst.overrun", 32'(overrun), 32'd0);
    reset = 1'b0;

    // Single tile from idle
    drive_cap(8'd1, 8'd2, 8'd3, 8'd4);
    tick();
    capture = 1'b0;
    chk("t1.ready_staged", 32'(ready), 32'd1);
    expect_out("t1.pre", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    tick(); expect_out("t1.f0", 1'b1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);
    tick(); expect_feed1("t1.f1", 8'd2, 8'd3);
    tick(); expect_out("t1.f2", 1'b0, 8'd0, 1'b1, 8'd4, 1'b1, 1'b1);
    tick(); expect_out("t1.idle", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);

    // Back-to-back: tile A captured during FEED1 of tile B
    drive_cap(8'd1, 8'd2, 8'd3, 8'd4);
    tick(); capture = 1'b0;
    tick(); expect_out("bb.B.f0", 1'b1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);
    tick(); expect_feed1("bb.B.f1", 8'd2, 8'd3);
    chk("bb.ready_f1", 32'(ready), 32'd1);
    drive_cap(8'd5, 8'd6, 8'd7, 8'd8);
    tick(); capture = 1'b0;
    expect_out("bb.B.f2", 1'b0, 8'd0, 1'b1, 8'd4, 1'b1, 1'b1);
    tick(); expect_out("bb.A.f0", 1'b1, 8'd5, 1'b0, 8'd0, 1'b1, 1'b0);
    tick(); expect_feed1("bb.A.f1", 8'd6, 8'd7);
    tick(); expect_out("bb.A.f2", 1'b0, 8'd0, 1'b1, 8'd8, 1'b1, 1'b1);
    tick(); expect_out("bb.idle", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("bb.overrun", 32'(overrun), 32'd0);

    // X, then Y staged in FEED1, Z captured coincident with launch of Y, W dropped in FEED0
    drive_cap(8'd21, 8'd22, 8'd23, 8'd24);
    tick(); capture = 1'b0;
    tick(); expect_out("ov.X.f0", 1'b1, 8'd21, 1'b0, 8'd0, 1'b1, 1'b0);
    tick(); expect_feed1("ov.X.f1", 8'd22, 8'd23);
    drive_cap(8'd31, 8'd32, 8'd33, 8'd34);
    tick();
    expect_out("ov.X.f2", 1'b0, 8'd0, 1'b1, 8'd24, 1'b1, 1'b1);
    chk("ov.ready_coincident", 32'(ready), 32'd1);
    drive_cap(8'd41, 8'd42, 8'd43, 8'd44);
    tick();
    expect_out("ov.Y.f0", 1'b1, 8'd31, 1'b0, 8'd0, 1'b1, 1'b0);
    chk("ov.overrun_pre", 32'(overrun), 32'd0);
    chk("ov.ready_full", 32'(ready), 32'd0);
    drive_cap(8'd51, 8'd52, 8'd53, 8'd54);
    tick(); capture = 1'b0;
    expect_feed1("ov.Y.f1", 8'd32, 8'd33);
    chk("ov.overrun_set", 32'(overrun), 32'd1);
    tick(); expect_out("ov.Y.f2", 1'b0, 8'd0, 1'b1, 8'd34, 1'b1, 1'b1);
    tick(); expect_out("ov.Z.f0", 1'b1, 8'd41, 1'b0, 8'd0, 1'b1, 1'b0);
    tick(); expect_feed1("ov.Z.f1", 8'd42, 8'd43);
    tick(); expect_out("ov.Z.f2", 1'b0, 8'd0, 1'b1, 8'd44, 1'b1, 1'b1);
    tick(); expect_out("ov.idle", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("ov.overrun_sticky", 32'(overrun), 32'd1);

    // Reset during FEED1
    drive_cap(8'd9, 8'd10, 8'd11, 8'd12);
    tick(); capture = 1'b0;
    tick(); expect_out("mr.f0", 1'b1, 8'd9, 1'b0, 8'd0, 1'b1, 1'b0);
    tick(); expect_feed1("mr.f1", 8'd10, 8'd11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_out("mr.abort", 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
    chk("mr.ready", 32'(ready), 32'd1);
    chk("mr.overrun_clr", 32'(overrun), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr.no_done", 32'(tile_done), 32'd0);
      chk("mr.no_busy", 32'(busy), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
